// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back/write-allocate data cache controller for the MEM stage.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_en_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 27 - IDXW;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, DONE} state_t;

  state_t            state_r, state_s;
  logic [255:0]      data_r [LINES];
  logic [TAGW-1:0]   tag_r  [LINES];
  logic [LINES-1:0]  valid_r, dirty_r;

  logic [IDXW-1:0]   idx_s;
  logic [TAGW-1:0]   tag_s;
  logic [2:0]        wsel_s;
  logic              hit_s;
  logic              store_hit_s, fill_s, stall_s;
  logic              mem_en_s, mem_we_s;
  logic [31:0]       mem_addr_s, rdata_s;
  logic [255:0]      mem_wdata_s;
  logic              unused_s;

  assign idx_s    = cpu_addr_i[5 +: IDXW];
  assign tag_s    = cpu_addr_i[31 -: TAGW];
  assign wsel_s   = cpu_addr_i[4:2];
  assign hit_s    = cpu_req_i & valid_r[idx_s] & (tag_r[idx_s] == tag_s);
  assign unused_s = ^cpu_addr_i[1:0];

  // Next-state and output decode; while stalled the CPU holds its address, so it indexes the victim line.
  always_comb begin
    state_s     = state_r;
    stall_s     = 1'b0;
    store_hit_s = 1'b0;
    fill_s      = 1'b0;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = 32'd0;
    mem_wdata_s = 256'd0;
    rdata_s     = 32'd0;
    case (state_r)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit_s) begin
            if (cpu_we_i) begin
              store_hit_s = 1'b1;
            end else begin
              rdata_s = data_r[idx_s][{wsel_s, 5'b00000} +: 32];
            end
          end else begin
            stall_s = 1'b1;
            if (valid_r[idx_s] & dirty_r[idx_s]) begin
              state_s = WRITEBACK;
            end else begin
              state_s = ALLOCATE;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      WRITEBACK: begin
        stall_s     = 1'b1;
        mem_en_s    = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = {tag_r[idx_s], idx_s, 5'b00000};
        mem_wdata_s = data_r[idx_s];
        if (mem_ack_i) begin
          state_s = ALLOCATE;
        end else begin
          state_s = WRITEBACK;
        end
      end
      ALLOCATE: begin
        stall_s    = 1'b1;
        mem_en_s   = 1'b1;
        mem_addr_s = {cpu_addr_i[31:5], 5'b00000};
        if (mem_ack_i) begin
          fill_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = ALLOCATE;
        end
      end
      DONE: begin
        stall_s = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign cpu_stall_o = stall_s;
  assign cpu_rdata_o = rdata_s;
  assign mem_en_o    = mem_en_s;
  assign mem_we_o    = mem_we_s;
  assign mem_addr_o  = mem_addr_s;
  assign mem_wdata_o = mem_wdata_s;

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Line status bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
    end else if (fill_s) begin
      valid_r[idx_s] <= 1'b1;
      dirty_r[idx_s] <= 1'b0;
    end else if (store_hit_s) begin
      dirty_r[idx_s] <= 1'b1;
    end
  end

  // Data and tag arrays are not reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (fill_s) begin
      data_r[idx_s] <= mem_rdata_i;
      tag_r[idx_s]  <= tag_s;
    end else if (store_hit_s) begin
      data_r[idx_s][{wsel_s, 5'b00000} +: 32] <= cpu_wdata_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        replay_r;
  logic [31:0] hit_cnt_r, miss_cnt_r;

  // Statistics; the access completing right after DONE is the replay of a miss, not a hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      replay_r   <= 1'b0;
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      replay_r <= (state_r == DONE);
      if ((state_r == IDLE) && hit_s && !replay_r) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if ((state_r == IDLE) && cpu_req_i && !hit_s) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_r;
  assign miss_cnt_o = miss_cnt_r;
`else
  assign hit_cnt_o  = 32'd0;
  assign miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table of CPU accesses with a reactive main-memory model.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall, mem_en, mem_we, mem_ack;
  logic [31:0]  mem_addr, hit_cnt, miss_cnt;
  logic [255:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  logic [31:0]  sb_q [$];
  logic [31:0]  golden [logic [31:0]];
  logic [255:0] mem_model [logic [26:0]];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic        miss;
    logic        wb;
    logic [31:0] wb_addr;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_0048) return 32'hDEAD_BEEF;
    else return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    if (golden.exists(a)) return golden[a];
    else return init_word(a);
  endfunction

  function automatic logic [255:0] mem_line(input logic [26:0] la);
    logic [255:0] l;
    if (mem_model.exists(la)) return mem_model[la];
    for (int w = 0; w < 8; w++) begin
      logic [2:0] wi;
      wi = w[2:0];
      l[w*32 +: 32] = init_word({la, wi, 2'b00});
    end
    return l;
  endfunction

  function automatic logic [255:0] gold_line(input logic [26:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) begin
      logic [2:0] wi;
      wi = w[2:0];
      l[w*32 +: 32] = gold_rd({la, wi, 2'b00});
    end
    return l;
  endfunction

  // One CPU access, entered just after a falling edge; plays main memory with an ack delay of dly cycles.
  task automatic do_access(input string name, input vec_t v);
    int stalls = 0, waitn = 0, wbs = 0, fills = 0, cyc = 0, unstable = 0, exp_stalls;
    logic busy = 1'b0, done = 1'b0, hold_we = 1'b0;
    logic [31:0] hold_addr = 32'd0;
    logic [255:0] hold_wdata = 256'd0;
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    if (!v.we) sb_q.push_back(v.rdata);
    while (!done && cyc < 200) begin
      #1;
      if (!cpu_stall) begin
        done = 1'b1;
        if (!v.we) check({name, " rdata"}, cpu_rdata, sb_q.pop_front());
        else golden[v.addr] = v.wdata;
      end else begin
        stalls++;
        if (mem_en) begin
          if (!busy) begin
            busy = 1'b1; waitn = 0;
            hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
          end else if (mem_addr !== hold_addr || mem_we !== hold_we || mem_wdata !== hold_wdata) begin
            unstable++;
          end
          if (waitn == v.dly) begin
            mem_ack = 1'b1; busy = 1'b0;
            if (mem_we) begin
              wbs++;
              check({name, " wb_addr"}, mem_addr, v.wb_addr);
              check({name, " wb_data"}, mem_wdata, gold_line(mem_addr[31:5]));
              mem_model[mem_addr[31:5]] = mem_wdata;
            end else begin
              fills++;
              check({name, " fetch_addr"}, mem_addr, {v.addr[31:5], 5'b00000});
              mem_rdata = mem_line(mem_addr[31:5]);
            end
          end else begin
            waitn++;
          end
        end
      end
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      cyc++;
    end
    cpu_req = 1'b0;
    exp_stalls = v.miss ? (2 + (v.dly + 1) * (v.wb ? 2 : 1)) : 0;
    check({name, " completed"}, done, 1'b1);
    check({name, " stall_cycles"}, stalls, exp_stalls);
    check({name, " writebacks"}, wbs, v.wb);
    check({name, " fetches"}, fills, v.miss);
    check({name, " mem_stable"}, unstable, 0);
    if (v.miss) exp_misses++;
    else exp_hits++;
  endtask

  task automatic check_stats(input string name);
`ifdef DCACHE_STATS_EN
    check({name, " hit_cnt"}, hit_cnt, exp_hits);
    check({name, " miss_cnt"}, miss_cnt, exp_misses);
`else
    check({name, " hit_cnt"}, hit_cnt, 0);
    check({name, " miss_cnt"}, miss_cnt, 0);
`endif
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 256'd0;

    //            we    addr          wdata         dly miss  wb    wb_addr       rdata
    vecs[0]  = '{1'b0, 32'h0000_0040, 32'h0,        2,  1'b1, 1'b0, 32'h0,        32'h5A5A_0040};
    vecs[1]  = '{1'b0, 32'h0000_0048, 32'h0,        0,  1'b0, 1'b0, 32'h0,        32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0044, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0044, 32'h0,        0,  1'b0, 1'b0, 32'h0,        32'h1234_5678};
    vecs[4]  = '{1'b0, 32'h0000_0240, 32'h0,        10, 1'b1, 1'b1, 32'h0000_0040, 32'h5A5A_0240};
    vecs[5]  = '{1'b0, 32'h0000_0044, 32'h0,        3,  1'b1, 1'b0, 32'h0,        32'h1234_5678};
    vecs[6]  = '{1'b1, 32'h0000_1000, 32'hAABB_CCDD, 1, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0,        0,  1'b0, 1'b0, 32'h0,        32'hAABB_CCDD};
    vecs[8]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 0, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 32'h0000_11FC, 32'h0,        1,  1'b1, 1'b1, 32'h0000_03E0, 32'h5A5A_11FC};
    vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,        0,  1'b1, 1'b0, 32'h0,        32'h0BAD_F00D};
    vecs[11] = '{1'b1, 32'hFFFF_FFE0, 32'hCAFE_0001, 2, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 32'h0000_1000, 32'h0,        0,  1'b0, 1'b0, 32'h0,        32'hAABB_CCDD};

    repeat (2) @(negedge clk);
    #1;
    check("reset stall", cpu_stall, 1'b0);
    check("reset mem_en", mem_en, 1'b0);
    check("reset mem_we", mem_we, 1'b0);
    check("reset rdata", cpu_rdata, 32'd0);
    check_stats("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_access($sformatf("vec%0d", i), vecs[i]);
      if (i == 4) check_stats("after vec4");
    end
    check_stats("after table");
    #1;
    check("idle rdata", cpu_rdata, 32'd0);
    check("idle stall", cpu_stall, 1'b0);

    // Reset pulse in the middle of a line fetch.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0060;
    #1 check("abort miss stall", cpu_stall, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("abort alloc mem_en", mem_en, 1'b1);
    check("abort alloc mem_we", mem_we, 1'b0);
    check("abort alloc addr", mem_addr, 32'h0000_0060);
    rst = 1'b1;
    #1 check("abort mem_en", mem_en, 1'b0);
    cpu_req = 1'b0;
    #1 check("abort stall", cpu_stall, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = {8{32'hFFFF_0000}};
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    #1;
    check("stray ack mem_en", mem_en, 1'b0);
    check("stray ack stall", cpu_stall, 1'b0);
    exp_hits = 0; exp_misses = 0;
    check_stats("after abort");
    do_access("reload", '{1'b0, 32'h0000_0060, 32'h0, 1, 1'b1, 1'b0, 32'h0, 32'h5A5A_0060});
    check_stats("final");
    check("scoreboard empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter: LINES, default 16, number of direct-mapped lines (power of 2, 2..64); IDXW = log2(LINES), TAGW = 27-IDXW.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 cpu_req_i  input  1  MEM-stage load/store request valid (MemRead|MemWrite).
REQ-005 cpu_we_i  input  1  1 = store, 0 = load.
REQ-006 cpu_addr_i  input  32  byte address (ALU result of MEM stage); word-aligned.
REQ-007 cpu_wdata_i  input  32  store data.
REQ-008 cpu_rdata_o  output  32  load data, valid when cpu_req_i & ~cpu_we_i & ~cpu_stall_o.
REQ-009 cpu_stall_o  output  1  freezes PC and all pipeline registers while high.
REQ-010 mem_en_o  output  1  main-memory request valid.
REQ-011 mem_we_o  output  1  1 = line write-back, 0 = line fetch.
REQ-012 mem_addr_o  output  32  line-aligned address (bits [4:0] = 0).
REQ-013 mem_wdata_o  output  256  write-back line.
REQ-014 mem_rdata_i  input  256  fetched line, valid with mem_ack_i.
REQ-015 mem_ack_i  input  1  one-cycle completion pulse for the current request.
REQ-016 hit_cnt_o, miss_cnt_o  output  32 each  statistics counters (see Configuration).

Function
REQ-017 Address split: offset = addr[4:0], word select = addr[4:2], index = addr[5 +: IDXW], tag = addr[31:5+IDXW]; per line: valid, dirty, tag, 256-bit data.
REQ-018 Hit = cpu_req_i & valid[index] & (tag[index] == addr tag), evaluated combinationally in IDLE.
REQ-019 Load hit: cpu_rdata_o = selected word, same cycle, cpu_stall_o = 0.
REQ-020 Store hit: selected word written and dirty set at the clock edge, cpu_stall_o = 0 (write-back, write-allocate).
REQ-021 cpu_stall_o = cpu_req_i & ~hit in IDLE, and 1 in every non-IDLE state.
REQ-022 FSM states IDLE, WRITEBACK, ALLOCATE, DONE.
REQ-023 IDLE -> WRITEBACK on miss with victim valid & dirty; IDLE -> ALLOCATE on miss otherwise.
REQ-024 WRITEBACK: mem_en_o=1, mem_we_o=1, mem_addr_o = {victim tag, index, 5'b0}, mem_wdata_o = victim data; on mem_ack_i -> ALLOCATE.
REQ-025 ALLOCATE: mem_en_o=1, mem_we_o=0, mem_addr_o = {addr[31:5], 5'b0}; on mem_ack_i line data = mem_rdata_i, tag updated, valid=1, dirty=0, -> DONE.
REQ-026 DONE: one cycle, cpu_stall_o=1, -> IDLE, where the replayed access hits (REQ-019/020).
REQ-027 mem_en_o and mem_we_o held stable from first assertion until mem_ack_i; mem_ack_i outside WRITEBACK/ALLOCATE ignored.
REQ-028 cpu_req_i low: no state change, cpu_stall_o=0, cpu_rdata_o = 0.
REQ-029 Miss-to-resume latency = 1 (IDLE) + wait for write-back ack (if dirty) + wait for fetch ack + 1 (DONE) cycles.

Reset
REQ-030 rst_i high: state=IDLE, all valid and dirty bits 0, counters 0, mem_en_o=0, mem_we_o=0, cpu_stall_o=0 while cpu_req_i low; data/tag arrays not cleared.
REQ-031 Reset mid-refill or mid-write-back aborts the transfer; a later mem_ack_i is ignored; the aborted line remains invalid.

Configuration
REQ-032 With DCACHE_STATS_EN defined: hit_cnt_o increments once per access completed without stall in IDLE; miss_cnt_o increments once per IDLE->WRITEBACK/ALLOCATE transition; both wrap at 2^32; DONE-cycle replays not counted as hits.
REQ-033 Without DCACHE_STATS_EN: hit_cnt_o and miss_cnt_o tied to 0, no counter flops.

Verification
REQ-034 After reset, load 0x0000_0040 -> stall, ALLOCATE at mem_addr 0x0000_0040, ack with line word2 = 0xDEAD_BEEF; DONE; load 0x48 returns 0xDEAD_BEEF, stall 0.
REQ-035 Store 0x1234_5678 to 0x44 (hit) -> no stall; load 0x44 next cycle returns 0x1234_5678.
REQ-036 Load 0x0000_0240 (same index, LINES=16, dirty) -> WRITEBACK to 0x0000_0040 with word1 = 0x1234_5678, then ALLOCATE 0x0000_0240.
REQ-037 mem_ack_i delayed 10 cycles -> stall held, mem outputs stable all 10 cycles.
REQ-038 rst_i pulsed during ALLOCATE -> mem_en_o 0 immediately; subsequent ack ignored; load same address misses again.
REQ-039 DCACHE_STATS_EN defined, sequence of REQ-034..036 -> miss_cnt_o = 2, hit_cnt_o = 3.
